// File: rtl/npc_pkg.sv
// Shared definitions for the NPC core pipeline: load encodings and the
// field layout of the execute->memory and memory->write-back buses.
package npc_pkg;

  typedef enum logic [2:0] {
    LD_NONE = 3'b000,
    LD_LB   = 3'b001,
    LD_LH   = 3'b010,
    LD_LW   = 3'b011,
    LD_LBU  = 3'b100,
    LD_LHU  = 3'b101
  } ld_type_e;

  localparam int LDINST_W = 3;
  localparam int RSTRB_W  = 4;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

  // exe_to_mem_bus, MSB first: {load_inst, d_regW, d_regAddr, alu_result, rstrb, load_data}
  function automatic int e2m_width(int aw, int dw);
    return 2 * dw + aw + LDINST_W + 1 + RSTRB_W;
  endfunction

  function automatic int e2m_rstrb_lsb(int dw);
    return dw;
  endfunction

  function automatic int e2m_alu_lsb(int dw);
    return dw + RSTRB_W;
  endfunction

  function automatic int e2m_addr_lsb(int dw);
    return 2 * dw + RSTRB_W;
  endfunction

  function automatic int e2m_regw_bit(int aw, int dw);
    return 2 * dw + RSTRB_W + aw;
  endfunction

  function automatic int e2m_inst_lsb(int aw, int dw);
    return 2 * dw + RSTRB_W + aw + 1;
  endfunction

  // mem_to_wb_bus, MSB first: {d_regW, d_regAddr, wb_data}
  function automatic int m2w_width(int aw, int dw);
    return 1 + aw + dw;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Handshake bundle between execute, the memory stage and write-back.
interface mem_stage_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic [2*DATA_WIDTH+ADDR_WIDTH+7:0] exe_to_mem_bus;
  logic                               exe_to_mem_valid;
  logic                               mem_to_exe_ready;
  logic [ADDR_WIDTH+DATA_WIDTH:0]     mem_to_wb_bus;
  logic                               mem_to_wb_valid;
  logic                               wb_to_mem_ready;

  modport slave (
    input  exe_to_mem_bus, exe_to_mem_valid, wb_to_mem_ready,
    output mem_to_exe_ready, mem_to_wb_bus, mem_to_wb_valid
  );

  modport master (
    output exe_to_mem_bus, exe_to_mem_valid, wb_to_mem_ready,
    input  mem_to_exe_ready, mem_to_wb_bus, mem_to_wb_valid
  );
endinterface

// File: rtl/mem_fifo2.sv
// Two-entry circular FIFO; ready/valid come from registered count only,
// and the head output reads as zero while empty.
module mem_fifo2 #(
  parameter int WIDTH = 38
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_ready
);
  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign o_ready = (r_count != 2'd2);
  assign o_valid = (r_count != 2'd0);
  assign w_push  = i_push && o_ready;
  assign w_pop   = i_pop && o_valid;
  assign o_data  = o_valid ? r_mem[r_rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is left unreset; the empty mask on o_data hides stale words.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end
endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: aligns/extends load data (or passes the ALU result)
// and queues results for write-back behind a valid/ready handshake.
module mem_stage
  import npc_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  mem_stage_if.slave  io,
  output logic        mem_misalign
);
  localparam int DW      = DATA_WIDTH;
  localparam int AW      = ADDR_WIDTH;
  localparam int RS_LSB  = e2m_rstrb_lsb(DW);
  localparam int ALU_LSB = e2m_alu_lsb(DW);
  localparam int AD_LSB  = e2m_addr_lsb(DW);
  localparam int RW_BIT  = e2m_regw_bit(AW, DW);
  localparam int LI_LSB  = e2m_inst_lsb(AW, DW);
  localparam int WB_W    = m2w_width(AW, DW);

  logic [DW-1:0]      w_load_data;
  logic [RSTRB_W-1:0] w_rstrb;
  logic [DW-1:0]      w_alu;
  logic [AW-1:0]      w_addr;
  logic               w_regw;
  ld_type_e           w_inst;
  logic [4:0]         w_shamt;
  logic [DW-1:0]      w_sh;
  logic [DW-1:0]      w_byte_hi;
  logic [DW-1:0]      w_half_hi;
  logic [DW-1:0]      w_wb_data;
  logic               w_is_load;
  logic               w_misalign;
  logic               w_push;
  logic               r_misalign;

  assign w_load_data = io.exe_to_mem_bus[DW-1:0];
  assign w_rstrb     = io.exe_to_mem_bus[RS_LSB +: RSTRB_W];
  assign w_alu       = io.exe_to_mem_bus[ALU_LSB +: DW];
  assign w_addr      = io.exe_to_mem_bus[AD_LSB +: AW];
  assign w_regw      = io.exe_to_mem_bus[RW_BIT];
  assign w_inst      = ld_type_e'(io.exe_to_mem_bus[LI_LSB +: LDINST_W]);

  assign w_shamt   = {w_alu[1:0], 3'b000};
  assign w_sh      = w_load_data >> w_shamt;
  // Park the selected byte/half at the top so an arithmetic shift extends it.
  assign w_byte_hi = w_sh << (DW - 8);
  assign w_half_hi = w_sh << (DW - 16);

  always_comb begin
    w_wb_data = w_alu;
    w_is_load = 1'b1;
    case (w_inst)
      LD_LB:   w_wb_data = DW'($signed(w_byte_hi) >>> (DW - 8));
      LD_LBU:  w_wb_data = w_byte_hi >> (DW - 8);
      LD_LH:   w_wb_data = DW'($signed(w_half_hi) >>> (DW - 16));
      LD_LHU:  w_wb_data = w_half_hi >> (DW - 16);
      LD_LW:   w_wb_data = w_load_data;
      default: w_is_load = 1'b0;
    endcase
    w_misalign = w_is_load && (w_rstrb == '0);
    if (w_misalign) w_wb_data = '0;
  end

  assign w_push = io.exe_to_mem_valid && io.mem_to_exe_ready;

  mem_fifo2 #(.WIDTH(WB_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (io.exe_to_mem_valid),
    .i_data  ({w_regw && (w_addr != '0), w_addr, w_wb_data}),
    .i_pop   (io.wb_to_mem_ready),
    .o_data  (io.mem_to_wb_bus),
    .o_valid (io.mem_to_wb_valid),
    .o_ready (io.mem_to_exe_ready)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_misalign <= 1'b0;
    else     r_misalign <= w_push && w_misalign;
  end

  assign mem_misalign = r_misalign;
endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized checks of mem_stage against a queue-based model.
module tb_mem_stage;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  logic mis;

  mem_stage_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bif ();

  mem_stage #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .io           (bif.slave),
    .mem_misalign (mis)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [37:0] q[$];
  logic exp_mis = 1'b0;

  function automatic logic [76:0] mk_bus(logic [2:0] li, logic regw, logic [4:0] addr,
                                         logic [31:0] alu, logic [3:0] rs, logic [31:0] ld);
    return {li, regw, addr, alu, rs, ld};
  endfunction

  function automatic logic is_mis(logic [76:0] b);
    int unsigned li;
    li = b[76:74];
    return (li >= 1 && li <= 5 && b[35:32] == 4'd0);
  endfunction

  function automatic logic [37:0] exp_entry(logic [76:0] b);
    int unsigned li, off, by, hf;
    logic [31:0] alu, ld, sh, d;
    logic [4:0]  addr;
    logic        regw;
    li   = b[76:74];
    regw = b[73];
    addr = b[72:68];
    alu  = b[67:36];
    ld   = b[31:0];
    off  = alu % 4;
    sh   = ld >> (8 * off);
    by   = sh % 256;
    hf   = sh % 65536;
    case (li)
      1:       d = (by >= 128) ? 32'(by) + 32'hFFFF_FF00 : 32'(by);
      2:       d = (hf >= 32768) ? 32'(hf) + 32'hFFFF_0000 : 32'(hf);
      3:       d = ld;
      4:       d = 32'(by);
      5:       d = 32'(hf);
      default: d = alu;
    endcase
    if (is_mis(b)) d = 32'd0;
    return {regw && (addr != 5'd0), addr, d};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge with inputs already driven.
  task automatic step();
    logic push, pop;
    logic [37:0] nb;
    logic nm;
    @(negedge clk);
    chk("wb_valid", 64'(bif.mem_to_wb_valid), 64'(q.size() != 0));
    chk("exe_ready", 64'(bif.mem_to_exe_ready), 64'(q.size() < 2));
    chk("wb_bus", 64'(bif.mem_to_wb_bus), (q.size() != 0) ? 64'(q[0]) : 64'd0);
    chk("misalign", 64'(mis), 64'(exp_mis));
    push = bif.exe_to_mem_valid && (q.size() < 2);
    pop  = (q.size() != 0) && bif.wb_to_mem_ready;
    nb   = exp_entry(bif.exe_to_mem_bus);
    nm   = is_mis(bif.exe_to_mem_bus);
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (push) q.push_back(nb);
    exp_mis = push && nm;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bif.exe_to_mem_bus   = '0;
    bif.exe_to_mem_valid = 1'b0;
    bif.wb_to_mem_ready  = 1'b1;
    #2;
    chk("rst_valid", 64'(bif.mem_to_wb_valid), 64'd0);
    chk("rst_ready", 64'(bif.mem_to_exe_ready), 64'd1);
    chk("rst_bus", 64'(bif.mem_to_wb_bus), 64'd0);
    chk("rst_mis", 64'(mis), 64'd0);
    #11 rst = 1'b0;
    @(posedge clk); #1;

    // lb sign-extend from byte 3, visible the next cycle
    bif.exe_to_mem_bus   = mk_bus(3'b001, 1'b1, 5'd7, 32'h8000_0003, 4'b1000, 32'h80AB_CDEF);
    bif.exe_to_mem_valid = 1'b1;
    step();
    bif.exe_to_mem_valid = 1'b0;
    chk("lb_const", 64'(bif.mem_to_wb_bus), 64'({1'b1, 5'd7, 32'hFFFF_FF80}));
    step();

    bif.exe_to_mem_bus   = mk_bus(3'b101, 1'b1, 5'd3, 32'h8000_0002, 4'b1100, 32'hBEEF_1234);
    bif.exe_to_mem_valid = 1'b1;
    step();
    chk("lhu_const", 64'(bif.mem_to_wb_bus), 64'({1'b1, 5'd3, 32'h0000_BEEF}));
    bif.exe_to_mem_bus   = mk_bus(3'b010, 1'b1, 5'd3, 32'h8000_0002, 4'b1100, 32'hBEEF_1234);
    step();
    bif.exe_to_mem_valid = 1'b0;
    chk("lh_const", 64'(bif.mem_to_wb_bus), 64'({1'b1, 5'd3, 32'hFFFF_BEEF}));
    step();

    bif.exe_to_mem_bus   = mk_bus(3'b000, 1'b1, 5'd0, 32'h1234_5678, 4'b0000, 32'hDEAD_BEEF);
    bif.exe_to_mem_valid = 1'b1;
    step();
    bif.exe_to_mem_valid = 1'b0;
    chk("x0_const", 64'(bif.mem_to_wb_bus), 64'({1'b0, 5'd0, 32'h1234_5678}));
    step();

    // backpressure: three offered, two accepted, then ordered drain
    bif.wb_to_mem_ready  = 1'b0;
    bif.exe_to_mem_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bif.exe_to_mem_bus = mk_bus(3'b000, 1'b1, 5'(i + 1), 32'h100 + 32'(i), 4'b1111, 32'h0);
      step();
    end
    chk("full_ready", 64'(bif.mem_to_exe_ready), 64'd0);
    bif.exe_to_mem_valid = 1'b0;
    bif.wb_to_mem_ready  = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // misaligned lh: one-cycle pulse, zero data
    bif.exe_to_mem_bus   = mk_bus(3'b010, 1'b1, 5'd9, 32'h0000_0003, 4'b0000, 32'hFFFF_FFFF);
    bif.exe_to_mem_valid = 1'b1;
    step();
    bif.exe_to_mem_valid = 1'b0;
    chk("mis_pulse", 64'(mis), 64'd1);
    chk("mis_data", 64'(bif.mem_to_wb_bus), 64'({1'b1, 5'd9, 32'h0}));
    step();
    chk("mis_clear", 64'(mis), 64'd0);
    step();

    // async reset with two entries queued
    bif.wb_to_mem_ready  = 1'b0;
    bif.exe_to_mem_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      bif.exe_to_mem_bus = mk_bus(3'b011, 1'b1, 5'd4, 32'h40, 4'b1111, 32'hA5A5_0000 + 32'(i));
      step();
    end
    bif.exe_to_mem_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 64'(bif.mem_to_wb_valid), 64'd0);
    chk("arst_ready", 64'(bif.mem_to_exe_ready), 64'd1);
    chk("arst_bus", 64'(bif.mem_to_wb_bus), 64'd0);
    q.delete();
    exp_mis = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    bif.wb_to_mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bif.exe_to_mem_valid = ($urandom % 4) != 0;
      bif.wb_to_mem_ready  = ($urandom % 3) != 0;
      bif.exe_to_mem_bus   = mk_bus(3'($urandom % 8), 1'($urandom), 5'($urandom),
                                    $urandom, (($urandom % 4) == 0) ? 4'd0 : 4'($urandom),
                                    $urandom);
      step();
    end
    bif.exe_to_mem_valid = 1'b0;
    bif.wb_to_mem_ready  = 1'b1;
    for (int i = 0; i < 3; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
